bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter W, default 32, binary input width (2..64).
REQ-002 SHALL have parameter DIGITS, default 10, BCD output digit count (1..20).
REQ-003 SHALL have parameter SIGNED, default 0; 1 = treat input as two's complement.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  conversion request.
REQ-007 in_ready  output  1  block can accept in_num this cycle.
REQ-008 in_num  input  W  binary operand.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_bcd  output  4*DIGITS  packed BCD, digit 0 at bits [3:0].
REQ-012 out_neg  output  1  result sign; always 0 when SIGNED=0.
REQ-013 out_ndigits  output  clog2(DIGITS+1)  significant digit count.
REQ-014 out_ovf  output  1  magnitude exceeded DIGITS digits.

Function
REQ-015 SHALL implement FSM IDLE -> SHIFT -> HOLD -> IDLE.
REQ-016 in_ready SHALL be 1 in IDLE, and in HOLD only when out_ready=1; otherwise 0.
REQ-017 On in_valid&&in_ready, SHALL latch magnitude (negated if SIGNED and in_num[W-1]=1), latch sign, clear BCD and ovf, load iteration counter with W, enter SHIFT.
REQ-018 Magnitude SHALL be an unsigned W-bit value; the most-negative input yields 2^(W-1) without error.
REQ-019 Each SHIFT cycle SHALL add 3 to every digit >= 5, then shift {BCD, magnitude} left by one bit, as one combined step.
REQ-020 Any 1 bit shifted out of the top digit SHALL set out_ovf sticky for the current conversion; the retained digits are the low DIGITS digits.
REQ-021 After exactly W SHIFT cycles the FSM SHALL enter HOLD with out_valid=1; latency from accept edge to out_valid is W+1 cycles.
REQ-022 In HOLD, out_bcd, out_neg, out_ndigits and out_ovf SHALL stay stable until out_valid&&out_ready.
REQ-023 On out_valid&&out_ready, SHALL return to IDLE, or go directly to SHIFT if a new operand is accepted in the same cycle.
REQ-024 out_ndigits SHALL equal the index of the highest nonzero digit plus 1, and 1 for a zero result; it is computed on entry to HOLD.
REQ-025 out_neg SHALL be 0 for a zero result, even if the input was negative.
REQ-026 in_valid during SHIFT SHALL be ignored; no operand is queued.
REQ-027 out_bcd, out_neg, out_ndigits and out_ovf outside HOLD SHALL hold the previous result (zero after reset).

Reset
REQ-028 rst SHALL force IDLE, out_valid=0, out_bcd=0, out_neg=0, out_ndigits=0, out_ovf=0, and clear the counter.
REQ-029 rst asserted mid-SHIFT SHALL abort the conversion with no output pulse; in_ready=1 on the cycle after rst deasserts.
REQ-030 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-031 Package bin2bcd_pkg SHALL hold the FSM state enum and the add-3 digit-adjust function.
REQ-032 Sub-module bcd_dabble_step (combinational: adjust all digits, shift one bit, report carry-out) SHALL be instantiated once.
REQ-033 Counter width SHALL be clog2(W+1); no other derived widths hard-coded.

Verification
REQ-034 W=32, DIGITS=10, in_num=32'hFFFFFFFF -> after 33 cycles out_bcd=40'h4294967295, ndigits=10, ovf=0, neg=0.
REQ-035 in_num=0 -> out_bcd=0, ndigits=1, ovf=0; then in_num=7 accepted in the same cycle as out_ready -> out_bcd=7, ndigits=1.
REQ-036 SIGNED=1, W=8, DIGITS=3, in_num=8'h80 -> out_bcd=12'h128, neg=1; in_num=8'hFF -> out_bcd=12'h001, neg=1.
REQ-037 W=8, DIGITS=2, in_num=255 -> out_bcd=8'h55, ovf=1, ndigits=2.
REQ-038 out_ready held 0 for 20 cycles in HOLD -> outputs stable and in_ready=0 throughout; in_valid pulses during SHIFT are ignored.
REQ-039 rst pulsed at SHIFT iteration 10 -> no out_valid, IDLE on the next cycle, subsequent conversion of 1234 -> out_bcd=...1234.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the per-digit add-3 adjust.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_step.sv
// One double-dabble iteration: adjust every digit, then shift {bcd, mag}
// left by one bit; the bit leaving the top digit is reported as carry_o.
module bcd_dabble_step
    import bin2bcd_pkg::*;
#(
    parameter int W      = 32,
    parameter int DIGITS = 10
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic [W-1:0]        mag_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic [W-1:0]        mag_o,
    output logic                carry_o
);

    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = dabble_adj(bcd_i[4*i +: 4]);
        end
    end

    assign {carry_o, bcd_o, mag_o} = {adj, mag_i, 1'b0};

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per cycle, with valid/ready
// handshakes on both sides and a stable result register held in HOLD.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 0,
    localparam int NW    = $clog2(DIGITS + 1),
    localparam int CW    = $clog2(W + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_num,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_neg,
    output logic [NW-1:0]       out_ndigits,
    output logic                out_ovf
);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        mag_q, mag_d;
    logic [4*DIGITS-1:0] work_q, work_d;
    logic                wovf_q, wovf_d;
    logic                sign_q, sign_d;
    logic [4*DIGITS-1:0] res_bcd_q, res_bcd_d;
    logic                res_neg_q, res_neg_d;
    logic [NW-1:0]       res_nd_q, res_nd_d;
    logic                res_ovf_q, res_ovf_d;

    logic [4*DIGITS-1:0] step_bcd;
    logic [W-1:0]        step_mag;
    logic                step_c;
    logic [NW-1:0]       step_nd;
    logic                accept;
    logic                neg_in;

    bcd_dabble_step #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_step (
        .bcd_i   (work_q),
        .mag_i   (mag_q),
        .bcd_o   (step_bcd),
        .mag_o   (step_mag),
        .carry_o (step_c)
    );

    // Digit count of the final step result; zero reads as one digit.
    always_comb begin
        step_nd = NW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (step_bcd[4*i +: 4] != 4'd0) step_nd = NW'(i + 1);
        end
    end

    assign in_ready  = (state_q == S_IDLE) ||
                       ((state_q == S_HOLD) && out_ready);
    assign out_valid = (state_q == S_HOLD);
    assign accept    = in_valid && in_ready;
    assign neg_in    = (SIGNED != 0) && in_num[W-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        work_d    = work_q;
        wovf_d    = wovf_q;
        sign_d    = sign_q;
        res_bcd_d = res_bcd_q;
        res_neg_d = res_neg_q;
        res_nd_d  = res_nd_q;
        res_ovf_d = res_ovf_q;
        unique case (state_q)
            S_IDLE: ;
            S_SHIFT: begin
                mag_d  = step_mag;
                work_d = step_bcd;
                wovf_d = wovf_q | step_c;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = S_HOLD;
                    res_bcd_d = step_bcd;
                    res_ovf_d = wovf_q | step_c;
                    res_neg_d = sign_q && (step_bcd != '0);
                    res_nd_d  = step_nd;
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new operand can be taken from IDLE or while the result drains.
        if (accept) begin
            state_d = S_SHIFT;
            cnt_d   = CW'(W);
            mag_d   = neg_in ? -in_num : in_num;
            sign_d  = neg_in;
            work_d  = '0;
            wovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            work_q    <= '0;
            wovf_q    <= 1'b0;
            sign_q    <= 1'b0;
            res_bcd_q <= '0;
            res_neg_q <= 1'b0;
            res_nd_q  <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            work_q    <= work_d;
            wovf_q    <= wovf_d;
            sign_q    <= sign_d;
            res_bcd_q <= res_bcd_d;
            res_neg_q <= res_neg_d;
            res_nd_q  <= res_nd_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign out_bcd     = res_bcd_q;
    assign out_neg     = res_neg_q;
    assign out_ndigits = res_nd_q;
    assign out_ovf     = res_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations, vector tables, random
// operands against a decimal-arithmetic model, and handshake corner cases.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_iv, a_ir, a_ov, a_or;
    logic [31:0] a_num;
    logic [39:0] a_bcd;
    logic        a_neg, a_ovf;
    logic [3:0]  a_nd;

    logic        b_iv, b_or;
    logic [7:0]  b_num;
    logic        s_ir, s_ov, s_neg, s_ovf;
    logic [11:0] s_bcd;
    logic [1:0]  s_nd;
    logic        t_ir, t_ov, t_neg, t_ovf;
    logic [7:0]  t_bcd;
    logic [1:0]  t_nd;

    int ncomp = 0;
    int nfail = 0;

    bin2bcd_seq #(.W(32), .DIGITS(10), .SIGNED(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
        .in_num(a_num), .out_valid(a_ov), .out_ready(a_or),
        .out_bcd(a_bcd), .out_neg(a_neg), .out_ndigits(a_nd),
        .out_ovf(a_ovf)
    );

    bin2bcd_seq #(.W(8), .DIGITS(3), .SIGNED(1)) u_s (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(s_ir),
        .in_num(b_num), .out_valid(s_ov), .out_ready(b_or),
        .out_bcd(s_bcd), .out_neg(s_neg), .out_ndigits(s_nd),
        .out_ovf(s_ovf)
    );

    bin2bcd_seq #(.W(8), .DIGITS(2), .SIGNED(0)) u_t (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(t_ir),
        .in_num(b_num), .out_valid(t_ov), .out_ready(b_or),
        .out_bcd(t_bcd), .out_neg(t_neg), .out_ndigits(t_nd),
        .out_ovf(t_ovf)
    );

    typedef struct {
        logic [31:0] n;
        logic [39:0] bcd;
        int          nd;
    } va_t;

    typedef struct {
        logic [7:0]  n;
        logic [11:0] sbcd;
        bit          sneg;
        int          snd;
        logic [7:0]  tbcd;
        bit          tovf;
        int          tnd;
    } vb_t;

    va_t va[6];
    vb_t vb[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncomp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal digits of mag, lowest first; overflow if anything is left.
    function automatic void model(input longint unsigned mag,
                                  input int digits,
                                  output logic [79:0] bcd,
                                  output int nd, output bit ovf);
        longint unsigned v;
        v = mag;
        bcd = '0;
        nd = 1;
        for (int i = 0; i < digits; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            if ((v % 10) != 0) nd = i + 1;
            v = v / 10;
        end
        ovf = (v != 0);
    endfunction

    task automatic start_a(input logic [31:0] n);
        int k;
        k = 0;
        while (!a_ir && k < 100) begin
            tick();
            k++;
        end
        if (!a_ir) chk("a_ready_timeout", 64'(a_ir), 64'd1);
        a_iv = 1'b1;
        a_num = n;
        tick();
        a_iv = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!a_ov && lat < 200) begin
            tick();
            lat++;
        end
        if (!a_ov) chk("a_valid_timeout", 64'(a_ov), 64'd1);
    endtask

    task automatic drain_a();
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
    endtask

    task automatic conv_a(input string nm, input logic [31:0] n);
        int lat, nd;
        logic [79:0] bcd;
        bit ovf;
        model(64'(n), 10, bcd, nd, ovf);
        start_a(n);
        wait_a(lat);
        chk({nm, "_lat"}, 64'(lat), 64'd32);
        chk({nm, "_bcd"}, 64'(a_bcd), 64'(bcd[39:0]));
        chk({nm, "_nd"}, 64'(a_nd), 64'(nd));
        chk({nm, "_ovf"}, 64'(a_ovf), 64'(ovf));
        chk({nm, "_neg"}, 64'(a_neg), 64'd0);
        drain_a();
    endtask

    task automatic conv_b(input logic [7:0] n);
        int k;
        k = 0;
        while (!s_ir && k < 100) begin
            tick();
            k++;
        end
        b_iv = 1'b1;
        b_num = n;
        tick();
        b_iv = 1'b0;
        k = 0;
        while (!s_ov && k < 100) begin
            tick();
            k++;
        end
        chk("b_lat", 64'(k), 64'd8);
        chk("b_tvalid", 64'(t_ov), 64'd1);
    endtask

    task automatic drain_b();
        b_or = 1'b1;
        tick();
        b_or = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, nd, nd2, hits;
        logic [79:0] bcd, bcd2;
        bit ovf, ovf2, neg;
        logic [31:0] r;
        logic [7:0] rb;
        longint unsigned mag;

        va[0] = '{32'hFFFFFFFF, 40'h4294967295, 10};
        va[1] = '{32'd0,          40'h0,          1};
        va[2] = '{32'd7,          40'h7,          1};
        va[3] = '{32'd1234,       40'h1234,       4};
        va[4] = '{32'd1000000000, 40'h1000000000, 10};
        va[5] = '{32'd999999999,  40'h0999999999, 9};

        vb[0] = '{8'h80, 12'h128, 1'b1, 3, 8'h28, 1'b1, 2};
        vb[1] = '{8'hFF, 12'h001, 1'b1, 1, 8'h55, 1'b1, 2};
        vb[2] = '{8'h00, 12'h000, 1'b0, 1, 8'h00, 1'b0, 1};
        vb[3] = '{8'h7F, 12'h127, 1'b0, 3, 8'h27, 1'b1, 2};
        vb[4] = '{8'h0A, 12'h010, 1'b0, 2, 8'h10, 1'b0, 2};
        vb[5] = '{8'h63, 12'h099, 1'b0, 2, 8'h99, 1'b0, 2};
        vb[6] = '{8'h64, 12'h100, 1'b0, 3, 8'h00, 1'b1, 1};
        vb[7] = '{8'hC8, 12'h056, 1'b1, 2, 8'h00, 1'b1, 1};

        rst = 1'b1;
        a_iv = 1'b1;
        a_num = 32'd55;
        a_or = 1'b1;
        b_iv = 1'b0;
        b_num = '0;
        b_or = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(a_ov), 64'd0);
        chk("rst_bcd", 64'(a_bcd), 64'd0);
        chk("rst_nd", 64'(a_nd), 64'd0);
        chk("rst_ovf", 64'(a_ovf), 64'd0);
        chk("rst_neg", 64'(a_neg), 64'd0);
        chk("rst_s_bcd", 64'(s_bcd), 64'd0);
        a_iv = 1'b0;
        a_or = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_prio_ready", 64'(a_ir), 64'd1);

        for (int i = 0; i < 6; i++) begin
            start_a(va[i].n);
            chk("va_shift_ready", 64'(a_ir), 64'd0);
            wait_a(lat);
            chk("va_lat", 64'(lat), 64'd32);
            chk("va_bcd", 64'(a_bcd), 64'(va[i].bcd));
            chk("va_nd", 64'(a_nd), 64'(va[i].nd));
            chk("va_ovf", 64'(a_ovf), 64'd0);
            chk("va_neg", 64'(a_neg), 64'd0);
            drain_a();
        end

        for (int i = 0; i < 8; i++) begin
            conv_b(vb[i].n);
            chk("vb_s_bcd", 64'(s_bcd), 64'(vb[i].sbcd));
            chk("vb_s_neg", 64'(s_neg), 64'(vb[i].sneg));
            chk("vb_s_nd", 64'(s_nd), 64'(vb[i].snd));
            chk("vb_s_ovf", 64'(s_ovf), 64'd0);
            chk("vb_t_bcd", 64'(t_bcd), 64'(vb[i].tbcd));
            chk("vb_t_ovf", 64'(t_ovf), 64'(vb[i].tovf));
            chk("vb_t_nd", 64'(t_nd), 64'(vb[i].tnd));
            chk("vb_t_neg", 64'(t_neg), 64'd0);
            drain_b();
        end

        for (int i = 0; i < 30; i++) begin
            r = $urandom;
            if (i % 3 == 0) r = r >> $urandom_range(0, 31);
            conv_a("rnd_a", r);
        end

        for (int i = 0; i < 30; i++) begin
            rb = 8'($urandom);
            mag = rb[7] ? 64'(256 - int'(rb)) : 64'(rb);
            model(mag, 3, bcd, nd, ovf);
            neg = rb[7] && (mag != 0);
            model(64'(rb), 2, bcd2, nd2, ovf2);
            conv_b(rb);
            chk("rnd_s_bcd", 64'(s_bcd), 64'(bcd[11:0]));
            chk("rnd_s_neg", 64'(s_neg), 64'(neg));
            chk("rnd_s_nd", 64'(s_nd), 64'(nd));
            chk("rnd_t_bcd", 64'(t_bcd), 64'(bcd2[7:0]));
            chk("rnd_t_ovf", 64'(t_ovf), 64'(ovf2));
            chk("rnd_t_nd", 64'(t_nd), 64'(nd2));
            drain_b();
        end

        start_a(32'd0);
        wait_a(lat);
        chk("zero_bcd", 64'(a_bcd), 64'd0);
        chk("zero_nd", 64'(a_nd), 64'd1);
        a_or = 1'b1;
        a_iv = 1'b1;
        a_num = 32'd7;
        #1;
        chk("b2b_ready", 64'(a_ir), 64'd1);
        tick();
        a_or = 1'b0;
        a_iv = 1'b0;
        chk("b2b_valid_low", 64'(a_ov), 64'd0);
        chk("b2b_shift_ready", 64'(a_ir), 64'd0);
        chk("b2b_held_bcd", 64'(a_bcd), 64'd0);
        wait_a(lat);
        chk("b2b_lat", 64'(lat), 64'd32);
        chk("b2b_bcd", 64'(a_bcd), 64'h7);
        chk("b2b_nd", 64'(a_nd), 64'd1);
        drain_a();

        start_a(32'd1234);
        for (int i = 0; i < 6; i++) begin
            a_iv = (i % 2 == 0);
            a_num = 32'd999;
            tick();
        end
        a_iv = 1'b0;
        chk("shift_iv_ready", 64'(a_ir), 64'd0);
        wait_a(lat);
        chk("shift_iv_lat", 64'(lat), 64'd26);
        chk("shift_iv_bcd", 64'(a_bcd), 64'h1234);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", 64'(a_ov), 64'd1);
            chk("hold_ready", 64'(a_ir), 64'd0);
            chk("hold_bcd", 64'(a_bcd), 64'h1234);
            chk("hold_nd", 64'(a_nd), 64'd4);
        end
        drain_a();
        chk("no_queue_valid", 64'(a_ov), 64'd0);
        chk("no_queue_ready", 64'(a_ir), 64'd1);
        repeat (3) tick();
        chk("no_queue_idle", 64'(a_ov), 64'd0);

        start_a(32'd98765);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 64'(a_ov), 64'd0);
        chk("abort_ready", 64'(a_ir), 64'd1);
        chk("abort_bcd", 64'(a_bcd), 64'd0);
        chk("abort_nd", 64'(a_nd), 64'd0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_ov) hits++;
        end
        chk("abort_no_pulse", 64'(hits), 64'd0);
        conv_a("after_abort", 32'd1234);
        chk("after_abort_exact", 64'(a_bcd), 64'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end

endmodule
